// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Instruction fetch/prefetch stage. It owns the fetch PC, issues sequential
//   64-bit word reads to instruction memory, and buffers the returned words,
//   each tagged with its address, in an in-order FIFO towards decode. A
//   redirect flushes the FIFO and marks every read still in flight as stale,
//   so those responses are discarded when they return.
// Parameters
//   RESET_PC  fetch address after reset (bits [2:0] ignored)
//   DEPTH     FIFO entries, power of 2, >= 2; also bounds outstanding reads
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr/_valid    fetch request address (= fetch PC) and valid
//   imem_addr_ready     memory accepts the request
//   imem_data/_valid    in-order read responses from memory
//   inst_data/inst_pc   FIFO head word and its address (registered)
//   inst_valid          FIFO head valid
//   inst_ready          decode pops the head
//   redirect_valid/_pc  single-cycle redirect pulse and target
module ifetch_prefetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  output logic        imem_addr_valid,
  input  logic        imem_addr_ready,
  input  logic [63:0] imem_data,
  input  logic        imem_data_valid,
  output logic [63:0] inst_data,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int          PW         = $clog2(DEPTH);
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [63:0] RESET_ADDR = RESET_PC & ~64'h7;
  localparam logic [CW:0] DEPTH_C    = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc_r, resp_pc_r;
  logic [CW-1:0] count_r, outstanding_r, drop_r;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [63:0]   head_data_r, head_pc_r;
  logic [63:0]   data_mem_r [DEPTH];
  logic [63:0]   pc_mem_r   [DEPTH];

  logic          room_s, accept_s, resp_s, push_s, pop_s;
  logic [63:0]   redirect_addr_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [63:0]   head_data_nxt_s, head_pc_nxt_s;

  assign imem_addr = fetch_pc_r;
  assign inst_data = head_data_r;
  assign inst_pc   = head_pc_r;

  // Handshake qualification and head-register next value.
  always_comb begin
    redirect_addr_s = redirect_pc & ~64'h7;
    room_s          = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C;
    // No requests while reset is asserted.
    imem_addr_valid = rst_n && !redirect_valid && room_s;
    inst_valid      = (count_r != CW'(0)) && !redirect_valid;
    accept_s        = imem_addr_valid && imem_addr_ready;
    pop_s           = inst_valid && inst_ready;
    // Responses arriving with nothing outstanding are not ours.
    resp_s          = imem_data_valid && (outstanding_r != CW'(0));
    push_s          = resp_s && !redirect_valid && (drop_r == CW'(0));
    rd_ptr_nxt_s    = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
    head_data_nxt_s = head_data_r;
    head_pc_nxt_s   = head_pc_r;
    if (redirect_valid) begin
      head_data_nxt_s = head_data_r;
      head_pc_nxt_s   = head_pc_r;
    end else if (push_s && (count_r == (pop_s ? CW'(1) : CW'(0)))) begin
      // FIFO is empty after this cycle's pop: the pushed word becomes head.
      head_data_nxt_s = imem_data;
      head_pc_nxt_s   = resp_pc_r;
    end else if (pop_s) begin
      head_data_nxt_s = data_mem_r[rd_ptr_nxt_s];
      head_pc_nxt_s   = pc_mem_r[rd_ptr_nxt_s];
    end else begin
      head_data_nxt_s = head_data_r;
      head_pc_nxt_s   = head_pc_r;
    end
  end

  // FIFO storage; entries are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= imem_data;
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

  // PCs, pointers, occupancy and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_ADDR;
      resp_pc_r     <= RESET_ADDR;
      count_r       <= CW'(0);
      outstanding_r <= CW'(0);
      drop_r        <= CW'(0);
      wr_ptr_r      <= PW'(0);
      rd_ptr_r      <= PW'(0);
      head_data_r   <= 64'h0;
      head_pc_r     <= 64'h0;
    end else begin
      head_data_r   <= head_data_nxt_s;
      head_pc_r     <= head_pc_nxt_s;
      // No request is accepted in a redirect cycle, so only the response
      // can change the in-flight count here.
      outstanding_r <= outstanding_r + (accept_s ? CW'(1) : CW'(0))
                                     - (resp_s   ? CW'(1) : CW'(0));
      if (redirect_valid) begin
        fetch_pc_r <= redirect_addr_s;
        resp_pc_r  <= redirect_addr_s;
        count_r    <= CW'(0);
        wr_ptr_r   <= PW'(0);
        rd_ptr_r   <= PW'(0);
        // Every read still in flight is stale. Earlier stale reads are
        // already part of outstanding, so this covers back-to-back redirects.
        drop_r     <= outstanding_r - (resp_s ? CW'(1) : CW'(0));
      end else begin
        fetch_pc_r <= accept_s ? (fetch_pc_r + 64'd8) : fetch_pc_r;
        resp_pc_r  <= push_s ? (resp_pc_r + 64'd8) : resp_pc_r;
        count_r    <= count_r + (push_s ? CW'(1) : CW'(0))
                              - (pop_s  ? CW'(1) : CW'(0));
        wr_ptr_r   <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        rd_ptr_r   <= rd_ptr_nxt_s;
        drop_r     <= (resp_s && (drop_r != CW'(0))) ? (drop_r - CW'(1)) : drop_r;
      end
    end
  end

endmodule
